// File: rtl/rand_pkg.sv
// Shared types and constants for the random-number dispenser.
// The LFSR taps live only in rand_lfsr10; this package holds the rest.
package rand_pkg;

  typedef enum logic [1:0] {IDLE, DRAW, DELIVER} rd_state_t;

  localparam int LFSR_W = 10;
  localparam logic [LFSR_W-1:0] LFSR_RESET = 10'h000;

  // A zero bound means the full LFSR range, which never includes 0x3FF.
  function automatic logic draw_accept(input logic [LFSR_W-1:0] state,
                                       input logic [LFSR_W-1:0] bound);
    draw_accept = (bound == '0) || (state < bound);
  endfunction

endpackage

// File: rtl/rand_lfsr10.sv
// Free-running 10-bit XNOR LFSR, period 1023; the all-ones state is the lock-up state
// and is unreachable from the reset value of zero.
module rand_lfsr10
  import rand_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= LFSR_RESET;
    end else begin
      q <= {q[3] ~^ q[0], q[LFSR_W-1:1]};
    end
  end

endmodule

// File: rtl/rand_dispenser.sv
// Round-robin dispenser of bounded random draws from one shared LFSR.
// Each requester gets a rejection-sampled value below its latched limit.
module rand_dispenser
  import rand_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] limit,
  output logic [N_REQ-1:0]       grant,
  output logic [WIDTH-1:0]       value,
  output logic                   busy
);

  localparam int PTR_W = $clog2(N_REQ);

  rd_state_t        r_state;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] r_owner;
  logic [WIDTH-1:0] r_limit;
  logic [N_REQ-1:0] r_grant;
  logic [WIDTH-1:0] r_value;
  logic             r_busy;

  logic [WIDTH-1:0] w_lfsr;
  logic             w_any;
  logic [PTR_W-1:0] w_pick;
  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;
  logic [WIDTH-1:0] w_pick_limit;
  logic [PTR_W-1:0] w_owner_next;
  logic [N_REQ-1:0] w_owner_onehot;

  rand_lfsr10 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (w_lfsr)
  );

  // Scan downward from the farthest candidate so the nearest one at or after rr_ptr wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_sum  = '0;
    w_idx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(N_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(N_REQ);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (req[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  always_comb begin
    w_pick_limit = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick == PTR_W'(i)) begin
        w_pick_limit = limit[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_owner_next   = (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + PTR_W'(1);
  assign w_owner_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_limit  <= '0;
      r_grant  <= '0;
      r_value  <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_grant <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_pick;
            r_limit <= w_pick_limit;
            r_state <= DRAW;
            r_busy  <= 1'b1;
          end
        end
        DRAW: begin
          // A dropped request abandons the draw but still yields the turn.
          if (!req[r_owner]) begin
            r_rr_ptr <= w_owner_next;
            r_state  <= IDLE;
            r_busy   <= 1'b0;
          end else if (draw_accept(w_lfsr, r_limit)) begin
            r_value <= w_lfsr;
            r_grant <= w_owner_onehot;
            r_state <= DELIVER;
          end
        end
        DELIVER: begin
          r_rr_ptr <= w_owner_next;
          r_state  <= IDLE;
          r_busy   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign value = r_value;
  assign busy  = r_busy;

endmodule

// File: tb/tb_rand_dispenser.sv
// Directed bench for rand_dispenser: LFSR sequence, bounds, round-robin order,
// abort and asynchronous reset during a draw.
module tb_rand_dispenser;
  import rand_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req   = '0;
  logic [39:0] limit = '0;
  logic [3:0]  grant;
  logic [9:0]  value;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int e      = 0;

  always #5 clk = ~clk;

  rand_dispenser #(.N_REQ(4), .WIDTH(10)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .limit (limit),
    .grant (grant),
    .value (value),
    .busy  (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    limit = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    e     = 0;
  endtask

  logic [3:0] rr_tab [2:15];
  logic       seen;
  int         busy_cnt;

  initial begin
    rr_tab = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h4,
               4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h1};

    // Reset state
    @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_value", 32'(value), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));
    check("rst_lfsr",  32'(dut.u_lfsr.q), 32'h0);
    reset = 1'b1;
    e = 0;

    // LFSR sequence with no requests
    check("lfsr_s0", 32'(dut.u_lfsr.q), 32'h000);
    step();
    check("lfsr_s1", 32'(dut.u_lfsr.q), 32'h200);
    step();
    check("lfsr_s2", 32'(dut.u_lfsr.q), 32'h300);
    step();
    check("lfsr_s3", 32'(dut.u_lfsr.q), 32'h380);
    step();
    check("lfsr_s4", 32'(dut.u_lfsr.q), 32'h3C0);
    seen = 1'b0;
    while (e < 1023) begin
      step();
      if (dut.u_lfsr.q == 10'h3FF) seen = 1'b1;
    end
    check("lfsr_period", 32'(dut.u_lfsr.q), 32'h000);
    check("lfsr_no_3ff", 32'(seen), 32'h0);
    check("idle_busy",   32'(busy), 32'h0);

    // Full range: requester 0, limit 0
    do_reset();
    step();
    req = 4'b0001;
    step();
    check("full_grant_e2", 32'(grant), 32'h0);
    check("full_busy_e2",  32'(busy),  32'h1);
    step();
    check("full_grant", 32'(grant), 32'h1);
    check("full_value", 32'(value), 32'h300);
    req = 4'b0000;
    step();
    check("full_grant_off", 32'(grant), 32'h0);
    check("full_busy_off",  32'(busy),  32'h0);

    // Bound of one: requester 2, limit 1; later limit change must be ignored
    do_reset();
    step();
    req = 4'b0100;
    limit[20 +: 10] = 10'd1;
    step();
    check("b1_busy_e2", 32'(busy), 32'h1);
    limit[20 +: 10] = 10'd0;
    busy_cnt = 1;
    while (grant == 4'b0000 && e < 1100) begin
      step();
      if (busy) busy_cnt++;
    end
    check("b1_edge",     32'(e),        32'd1024);
    check("b1_grant",    32'(grant),    32'h4);
    check("b1_value",    32'(value),    32'h0);
    check("b1_busy_cnt", 32'(busy_cnt), 32'd1023);
    req = 4'b0000;
    step();
    check("b1_grant_off", 32'(grant), 32'h0);
    check("b1_busy_off",  32'(busy),  32'h0);

    // Round-robin with all four requesting, limits 0
    do_reset();
    step();
    req = 4'b1111;
    while (e < 15) begin
      step();
      check($sformatf("rr_grant_e%0d", e), 32'(grant), 32'(rr_tab[e]));
      if (e == 3)  check("rr_value_e3",  32'(value), 32'h300);
      if (e == 4)  check("rr_hold_e4",   32'(value), 32'h300);
      if (e == 6)  check("rr_value_e6",  32'(value), 32'h3E0);
      if (e == 9)  check("rr_value_e9",  32'(value), 32'h1FC);
      if (e == 12) check("rr_value_e12", 32'(value), 32'h23F);
      if (e == 15) check("rr_value_e15", 32'(value), 32'h3C7);
    end
    req = 4'b0000;
    step();

    // Abort: requester 1 drops its request while drawing
    do_reset();
    step();
    req = 4'b0010;
    limit[10 +: 10] = 10'd1;
    step();
    check("ab_busy_e2", 32'(busy), 32'h1);
    step();
    step();
    check("ab_grant_e4", 32'(grant), 32'h0);
    req = 4'b0000;
    step();
    check("ab_grant_e5", 32'(grant), 32'h0);
    check("ab_busy_e5",  32'(busy),  32'h0);
    check("ab_state_e5", 32'(dut.r_state), 32'(IDLE));
    req = 4'b0011;
    limit = '0;
    step();
    check("ab_busy_e6", 32'(busy), 32'h1);
    step();
    check("ab_grant_e7", 32'(grant), 32'h1);
    check("ab_value_e7", 32'(value), 32'h3F0);

    // Reset mid-draw: requester 2 with limit 1 is still drawing at e10
    req = 4'b0100;
    limit[20 +: 10] = 10'd1;
    step();
    step();
    step();
    check("mr_busy_pre",  32'(busy), 32'h1);
    check("mr_state_pre", 32'(dut.r_state), 32'(DRAW));
    #3;
    reset = 1'b0;
    #1;
    check("mr_busy",  32'(busy),  32'h0);
    check("mr_grant", 32'(grant), 32'h0);
    check("mr_value", 32'(value), 32'h0);
    check("mr_state", 32'(dut.r_state), 32'(IDLE));
    check("mr_lfsr",  32'(dut.u_lfsr.q), 32'h0);
    req = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (grant != 4'b0000 || busy) seen = 1'b1;
    end
    check("mr_quiet", 32'(seen), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rand_dispenser.md
# rand_dispenser

Shares one free-running 10-bit XNOR LFSR between up to `N_REQ` game-logic requesters, for example spawn position, delay timer and colour pick. Requesters are served one at a time under round-robin arbitration. Each request carries an upper bound, and the block returns a uniformly distributed value below that bound using rejection sampling. The block sits between the LFSR and all consumers of random numbers, so no two consumers ever receive the same draw.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..8).
- `WIDTH`, default 10: LFSR and value width. Fixed at 10; the tap set depends on it.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in N_REQ: per-requester request level. Held high until grant or abort.
- `limit` in N_REQ*WIDTH: per-requester exclusive bound. Slice i belongs to requester i. 0 means full range.
- `grant` out N_REQ: one-hot, one-cycle pulse marking the owner of `value`.
- `value` out WIDTH: drawn value. Valid only in the cycle `grant` is nonzero; otherwise it holds its last value.
- `busy` out 1: high in DRAW and DELIVER.

## Operation
- **LFSR**
  - Advances every cycle, independent of the FSM: q <= {xnor(q[3], q[0]), q[9:1]}.
  - Reset value is 0. Period is 1023. State 0x3FF is never reached.
- **FSM states:** IDLE, DRAW, DELIVER.
- **IDLE**
  - If any `req` bit is high, pick the first set bit at or after `rr_ptr`, wrapping modulo N_REQ.
  - Latch that owner index and its `limit` slice, then go to DRAW.
- **DRAW**
  - Each cycle, compare the current LFSR state with the latched limit.
  - Accept if limit == 0, or if the state < limit.
  - On accept, register the state into `value`, set `grant[owner]`, and go to DELIVER.
  - On reject, stay in DRAW.
- **DELIVER**
  - `grant` is high for exactly this cycle.
  - Set `rr_ptr` = owner+1 mod N_REQ, then return to IDLE.
- **Abort:** if `req[owner]` is low while in DRAW, return to IDLE with no grant. `rr_ptr` still advances past the owner.
- **Limit sampling:** `limit` is sampled once, in IDLE. Later changes have no effect on the current draw.
- **Re-requests:** a requester that keeps `req` high after its grant is treated as a new request. It competes in the next IDLE cycle under round-robin order.
- **Termination bound:** the LFSR visits every value 0..1022 within 1023 cycles. Any limit in 1..1023 is therefore accepted within 1023 DRAW cycles. Limit 1023 draws 0..1022 uniformly; limit 0 also draws 0..1022.
- **Reset values:**
  - `grant` = 0, `value` = 0, `busy` = 0.
  - FSM = IDLE, `rr_ptr` = 0, LFSR = 0.
- **Reset mid-operation:** reset takes effect immediately (asynchronous). An in-flight draw is lost and no grant is issued.

## Timing
- `req` is sampled at edge E0 (in IDLE) → DRAW from E0.
- The first compare happens in the cycle after E0. On accept, `grant` and `value` appear after edge E1.
- Minimum latency is 2 edges from the sampling edge to `grant` visible.
- Each reject adds 1 cycle. Worst case is 1024 edges.
- After DELIVER there is 1 cycle in IDLE before the next arbitration.
- Back-to-back grants are therefore at least 3 cycles apart.
- `busy` is registered. It rises with DRAW entry and falls on return to IDLE.

## Structure
- Package `rand_pkg`:
  - `typedef enum logic [1:0] {IDLE, DRAW, DELIVER} rd_state_t`.
  - `localparam LFSR_W = 10`.
  - `localparam LFSR_RESET = 10'h000`.
- Sub-module `rand_lfsr10`:
  - Ports: `clk`, `reset` (active-low, async), `q[9:0]`.
  - Implements the shift/XNOR rule above. It is the only place the taps live.
- Top level holds the FSM, the round-robin pointer, the owner/limit latches and the output registers.

## Test plan
- **LFSR sequence:** release reset, hold `req` = 0. Probe `q`: the sequence must be 0x000, 0x200, 0x300, 0x380. After 1023 cycles `q` must be 0x000 again, and it must never be 0x3FF.
- **Full range:** `req[0]` = 1, limit0 = 0, raised one cycle after reset release.
  - `grant` must be 4'b0001 exactly 2 edges after the sampling edge.
  - `value` must equal the LFSR state at the compare cycle.
- **Bound of one:** `req[2]` = 1, limit2 = 1.
  - `value` must be 0.
  - `busy` high time must be ≤1024 cycles.
  - `grant` = 4'b0100 for one cycle.
- **Round-robin:** `req` = 4'b1111 held, all limits 0. Grants must occur in order 0001, 0010, 0100, 1000, 0001, at 3-cycle spacing.
- **Abort:** `req[1]` = 1 with limit1 = 1. Drop it 3 cycles into DRAW.
  - No grant is issued; FSM returns to IDLE.
  - A following `req` = 4'b0011 must be granted to requester 0.
- **Reset mid-draw:** assert `reset` low during DRAW. Outputs must go to 0 and FSM to IDLE immediately, with no grant after release until a new request.
